// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill controller.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FILL  = 2'd2,
        ST_DRAIN = 2'd3
    } refill_state_e;

    localparam int unsigned LINE_BYTES = 8;
    localparam int unsigned OFFSET_W   = 3;

    // Clears the byte-offset bits so the address points at the start of its line.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Miss/refill sequencer between fetch PC, instruction cache and instruction memory.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | no miss in flight; a miss stalls the PC combinationally
//   ST_REQ   | line read outstanding, data still wanted
//   ST_FILL  | one-cycle cache write of the captured line
//   ST_DRAIN | redirect abandoned the miss; wait out the ack, drop data
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned LINE_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              inp_clk,
    input  logic              inp_rst_n,
    input  logic [ADDR_W-1:0] inp_address,
    input  logic              inp_valid,
    input  logic              inp_hit,
    input  logic              inp_redirect,
    output logic              out_stall,
    output logic              out_memReq,
    output logic [ADDR_W-1:0] out_memAddr,
    input  logic              inp_memAck,
    input  logic [LINE_W-1:0] inp_memData,
    output logic              out_fillEn,
    output logic [ADDR_W-1:0] out_fillAddr,
    output logic [LINE_W-1:0] out_fillData,
    output logic              out_memErr,
    output logic [15:0]       out_missCount,
    output logic              out_busy
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    refill_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic              memreq_q, memreq_d;
    logic              memerr_q, memerr_d;

    logic              miss;
    logic              miss_start;
    logic              waiting;
    logic              tmo_last;
    logic              stall;
    logic              fill_en;
    logic [15:0]       tmo_cnt;
    logic [ADDR_W-1:0] line_addr;

    assign miss      = inp_valid & ~inp_hit & ~inp_redirect;
    assign line_addr = ADDR_W'(line_align(32'(inp_address)));
    assign waiting   = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    // Abort on the cycle whose increment would bring the wait count to TIMEOUT.
    assign tmo_last  = waiting & ~inp_memAck & (tmo_cnt == TMO_LAST);

    sat_counter #(.W(16)) u_miss_cnt (
        .clk_i  (inp_clk),
        .rst_ni (inp_rst_n),
        .clr_i  (1'b0),
        .inc_i  (miss_start),
        .cnt_o  (out_missCount)
    );

    sat_counter #(.W(16)) u_tmo_cnt (
        .clk_i  (inp_clk),
        .rst_ni (inp_rst_n),
        .clr_i  (miss_start),
        .inc_i  (waiting & ~inp_memAck),
        .cnt_o  (tmo_cnt)
    );

    // Next-state, latch updates and combinational outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        stall      = 1'b0;
        fill_en    = 1'b0;
        miss_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    stall      = 1'b1;
                    miss_start = 1'b1;
                    addr_d     = line_addr;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (inp_memAck) begin
                    if (!inp_redirect) begin
                        data_d  = inp_memData;
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmo_last) begin
                    state_d = ST_IDLE;
                end else if (inp_redirect) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FILL: begin
                stall   = 1'b1;
                fill_en = 1'b1;
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                stall = inp_valid & ~inp_hit;
                if (inp_memAck || tmo_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign memreq_d = (state_d == ST_REQ) || (state_d == ST_DRAIN);
    assign memerr_d = tmo_last;

    // State, latches and registered handshake outputs.
    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            memreq_q <= 1'b0;
            memerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            memreq_q <= memreq_d;
            memerr_q <= memerr_d;
        end
    end

    assign out_stall    = stall;
    assign out_memReq   = memreq_q;
    assign out_memAddr  = addr_q;
    assign out_fillEn   = fill_en;
    assign out_fillAddr = addr_q;
    assign out_fillData = data_q;
    assign out_memErr   = memerr_q;
    assign out_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed scenarios then random traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_icache_refill_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] t_addr = '0;
    logic        t_valid = 1'b0;
    logic        t_hit = 1'b0;
    logic        t_redir = 1'b0;
    logic        t_ack = 1'b0;
    logic [63:0] t_data = '0;

    logic        out_stall, out_memReq, out_fillEn, out_memErr, out_busy;
    logic [15:0] out_memAddr, out_fillAddr, out_missCount;
    logic [63:0] out_fillData;

    always #5 clk = ~clk;

    icache_refill_ctrl #(.ADDR_W(16), .LINE_W(64), .TIMEOUT(TMO)) dut (
        .inp_clk       (clk),
        .inp_rst_n     (rst_n),
        .inp_address   (t_addr),
        .inp_valid     (t_valid),
        .inp_hit       (t_hit),
        .inp_redirect  (t_redir),
        .out_stall     (out_stall),
        .out_memReq    (out_memReq),
        .out_memAddr   (out_memAddr),
        .inp_memAck    (t_ack),
        .inp_memData   (t_data),
        .out_fillEn    (out_fillEn),
        .out_fillAddr  (out_fillAddr),
        .out_fillData  (out_fillData),
        .out_memErr    (out_memErr),
        .out_missCount (out_missCount),
        .out_busy      (out_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: an outstanding-read flag, whether its data is still
    // wanted, a one-shot fill and one-shot error, and a wait-cycle count.
    bit          m_pend, m_keep, m_fill, m_err;
    int          m_wait;
    int          m_miss;
    logic [15:0] m_line;
    logic [63:0] m_data;

    task automatic model_reset();
        m_pend = 0; m_keep = 0; m_fill = 0; m_err = 0;
        m_wait = 0; m_miss = 0; m_line = '0; m_data = '0;
    endtask

    task automatic model_step();
        bit was_pend;
        bit was_fill;
        was_pend = m_pend;
        was_fill = m_fill;
        m_err  = 0;
        m_fill = 0;
        if (was_pend) begin
            if (t_ack) begin
                m_pend = 0;
                if (m_keep && !t_redir) begin
                    m_fill = 1;
                    m_data = t_data;
                end
            end else begin
                m_wait++;
                if (m_wait == TMO) begin
                    m_pend = 0;
                    m_err  = 1;
                end else if (t_redir) begin
                    m_keep = 0;
                end
            end
        end else if (!was_fill && t_valid && !t_hit && !t_redir) begin
            m_pend = 1;
            m_keep = 1;
            m_wait = 0;
            m_line = t_addr & 16'hFFF8;
            if (m_miss < 65535) m_miss++;
        end
    endtask

    task automatic check_outputs();
        logic e_stall;
        if (m_fill)      e_stall = 1'b1;
        else if (m_pend) e_stall = m_keep ? 1'b1 : (t_valid & ~t_hit);
        else             e_stall = t_valid & ~t_hit & ~t_redir;
        check("stall",     out_stall,     e_stall);
        check("memReq",    out_memReq,    m_pend);
        check("memAddr",   out_memAddr,   m_line);
        check("fillEn",    out_fillEn,    m_fill);
        check("fillAddr",  out_fillAddr,  m_line);
        check("fillData",  out_fillData,  m_data);
        check("memErr",    out_memErr,    m_err);
        check("missCount", out_missCount, 64'(m_miss));
        check("busy",      out_busy,      m_pend | m_fill);
    endtask

    // Called just after a falling edge: drive inputs, then compare outputs.
    task automatic step_in(input logic v, input logic h, input logic r,
                           input logic [15:0] a, input logic k, input logic [63:0] d);
        t_valid = v; t_hit = h; t_redir = r; t_addr = a; t_ack = k; t_data = d;
        #1;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},  out_stall,     0);
        check({tag, "_memReq"}, out_memReq,    0);
        check({tag, "_fillEn"}, out_fillEn,    0);
        check({tag, "_memErr"}, out_memErr,    0);
        check({tag, "_busy"},   out_busy,      0);
        check({tag, "_addr"},   out_memAddr,   0);
        check({tag, "_data"},   out_fillData,  0);
        check({tag, "_miss"},   out_missCount, 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // 1: hit stream
        for (int i = 0; i < 3; i++) begin
            step_in(1, 1, 0, 16'h0010, 0, '0);
            check("t1_stall", out_stall, 0);
            tick();
        end
        check("t1_miss", out_missCount, 0);

        // 2: miss, ack on the fifth request cycle
        step_in(1, 0, 0, 16'h0036, 0, '0);
        check("t2_stall_miss", out_stall, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            step_in(1, 0, 0, 16'h0036, 0, '0);
            check("t2_memAddr", out_memAddr, 16'h0030);
            tick();
        end
        step_in(1, 0, 0, 16'h0036, 1, 64'hAAAA_BBBB_CCCC_DDDD);
        tick();
        step_in(1, 0, 0, 16'h0036, 0, '0);
        check("t2_fillEn",   out_fillEn,   1);
        check("t2_fillAddr", out_fillAddr, 16'h0030);
        check("t2_fillData", out_fillData, 64'hAAAA_BBBB_CCCC_DDDD);
        tick();
        step_in(1, 1, 0, 16'h0036, 0, '0);
        check("t2_idle", out_busy, 0);
        check("t2_miss", out_missCount, 1);
        tick();

        // 3: redirect two cycles into REQ, then drain
        step_in(1, 0, 0, 16'h0040, 0, '0);
        tick();
        step_in(1, 0, 0, 16'h0040, 0, '0); tick();
        step_in(1, 0, 0, 16'h0040, 0, '0); tick();
        step_in(1, 0, 1, 16'h0040, 0, '0); tick();
        for (int i = 0; i < 3; i++) begin
            step_in(1, 1, 0, 16'h0100, (i == 2) ? 1'b1 : 1'b0, 64'h1111_2222_3333_4444);
            check("t3_drain_req",   out_memReq, 1);
            check("t3_drain_stall", out_stall,  0);
            tick();
        end
        step_in(1, 1, 0, 16'h0100, 0, '0);
        check("t3_nofill", out_fillEn, 0);
        check("t3_reqoff", out_memReq, 0);
        tick();

        // 4: ack and redirect together on the first REQ cycle
        step_in(1, 0, 0, 16'h0058, 0, '0); tick();
        step_in(1, 0, 1, 16'h0058, 1, 64'h5555_6666_7777_8888); tick();
        step_in(1, 1, 0, 16'h0200, 0, '0);
        check("t4_idle",   out_busy,   0);
        check("t4_nofill", out_fillEn, 0);
        tick();

        // 5: timeout
        step_in(1, 0, 0, 16'h0108, 0, '0); tick();
        for (int i = 0; i < TMO; i++) begin
            step_in(1, 0, 0, 16'h0108, 0, '0);
            check("t5_memErr_early", out_memErr, 0);
            tick();
        end
        step_in(0, 0, 0, 16'h0108, 0, '0);
        check("t5_memErr", out_memErr, 1);
        check("t5_memReq", out_memReq, 0);
        check("t5_busy",   out_busy,   0);
        tick();
        step_in(0, 0, 0, 16'h0108, 0, '0);
        check("t5_memErr_pulse", out_memErr, 0);
        tick();

        // 6: saturation of the miss counter
        force dut.u_miss_cnt.cnt_q = 16'hFFFE;
        #1;
        release dut.u_miss_cnt.cnt_q;
        m_miss = 16'hFFFE;
        for (int j = 0; j < 3; j++) begin
            step_in(1, 0, 0, 16'h0300, 0, '0); tick();
            step_in(1, 0, 0, 16'h0300, 1, 64'(j)); tick();
            step_in(1, 0, 0, 16'h0300, 0, '0); tick();
        end
        step_in(1, 1, 0, 16'h0300, 0, '0);
        check("t6_sat", out_missCount, 16'hFFFF);
        tick();

        // 6b: reset in the middle of a request, then a stray ack
        step_in(1, 0, 0, 16'h0400, 0, '0); tick();
        step_in(1, 0, 0, 16'h0400, 0, '0);
        check("t6_inreq", out_memReq, 1);
        rst_n = 1'b0; t_valid = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step_in(0, 0, 0, 16'h0400, 1, 64'hDEAD_BEEF_0000_0001); tick();
        step_in(0, 0, 0, 16'h0400, 0, '0);
        check("t6_stray_ack", out_fillEn, 0);
        tick();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            logic        v, h, r, k;
            logic [15:0] a;
            logic [63:0] d;
            v = ($urandom_range(0, 9) < 8);
            h = $urandom_range(0, 1) == 1;
            r = ($urandom_range(0, 99) < 15);
            k = ($urandom_range(0, 3) == 0);
            a = 16'($urandom);
            d = {$urandom, $urandom};
            step_in(v, h, r, a, k, d);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
